// File: rtl/idct4_pipe.sv
// idct4_pipe: three-stage 4-point HEVC inverse butterfly with round, shift and saturation
module idct4_pipe #(
  parameter int WIDTH_Y = 19,
  parameter int WIDTH_X = 10,
  parameter int SHIFT   = 14
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_Y-1:0] y0,
  input  logic signed [WIDTH_Y-1:0] y1,
  input  logic signed [WIDTH_Y-1:0] y2,
  input  logic signed [WIDTH_Y-1:0] y3,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_X-1:0] x0,
  output logic signed [WIDTH_X-1:0] x1,
  output logic signed [WIDTH_X-1:0] x2,
  output logic signed [WIDTH_X-1:0] x3,
  output logic                      sat
);
  localparam int W = WIDTH_Y + 9;
  localparam logic signed [W-1:0] rnd = W'(1) << (SHIFT - 1);
  localparam logic signed [W-1:0] hi = (W'(1) << (WIDTH_X - 1)) - W'(1);
  localparam logic signed [W-1:0] lo = ~hi;
  function automatic logic signed [W-1:0] m83(input logic signed [W-1:0] v);
    return (v <<< 6) + (v <<< 4) + (v <<< 1) + v;
  endfunction
  function automatic logic signed [W-1:0] m36(input logic signed [W-1:0] v);
    return (v <<< 5) + (v <<< 2);
  endfunction
  function automatic logic [WIDTH_X:0] clip(input logic signed [W-1:0] s);
    logic signed [W-1:0] q;
    q = (s + rnd) >>> SHIFT;
    return q > hi ? {1'b1, hi[WIDTH_X-1:0]} : q < lo ? {1'b1, lo[WIDTH_X-1:0]} : {1'b0, q[WIDTH_X-1:0]};
  endfunction
  logic en, v1, v2;
  logic signed [W-1:0] a0, a1, a2, a3, e0, e1, o0, o1;
  logic [WIDTH_X:0] c0, c1, c2, c3;
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  // S1: capture the accepted coefficient set, sign-extended to the internal width
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      {a0, a1, a2, a3} <= '0;
    end else if (en) begin
      v1 <= in_valid;
      if (in_valid) begin
        a0 <= W'(y0);
        a1 <= W'(y1);
        a2 <= W'(y2);
        a3 <= W'(y3);
      end
    end
  end
  // S2: even/odd partial products using shift-and-add constant multiplies
  always_ff @(posedge clk) begin
    if (rst) begin
      v2 <= 1'b0;
      {e0, e1, o0, o1} <= '0;
    end else if (en) begin
      v2 <= v1;
      e0 <= (a0 + a2) <<< 6;
      e1 <= (a0 - a2) <<< 6;
      o0 <= m83(a1) + m36(a3);
      o1 <= m36(a1) - m83(a3);
    end
  end
  // S3 combinational: butterfly sums followed by round, floor shift and clip
  always_comb begin
    c0 = clip(e0 + o0);
    c1 = clip(e1 + o1);
    c2 = clip(e1 - o1);
    c3 = clip(e0 - o0);
  end
  // S3: output register, held while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      {x0, x1, x2, x3} <= '0;
      sat <= 1'b0;
    end else if (en) begin
      out_valid <= v2;
      x0 <= c0[WIDTH_X-1:0];
      x1 <= c1[WIDTH_X-1:0];
      x2 <= c2[WIDTH_X-1:0];
      x3 <= c3[WIDTH_X-1:0];
      sat <= c0[WIDTH_X] | c1[WIDTH_X] | c2[WIDTH_X] | c3[WIDTH_X];
    end
  end
endmodule

// File: tb/tb_idct4_pipe.sv
// tb_idct4_pipe: scoreboard bench for the 4-point inverse butterfly pipeline
module tb_idct4_pipe;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, sat;
  logic signed [18:0] y0 = 0, y1 = 0, y2 = 0, y3 = 0;
  logic signed [9:0] x0, x1, x2, x3;
  logic [40:0] q[$];
  int vectors = 0, errors = 0;

  idct4_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid), .out_ready(out_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .sat(sat)
  );

  always #5 clk = ~clk;

  // reference: plain integer multiplies, floor shift, clip; packed {sat, x0, x1, x2, x3}
  function automatic logic [40:0] model(input int a, input int b, input int c, input int d);
    longint e0, e1, o0, o1, v;
    longint s[4];
    logic [40:0] r;
    e0 = 64 * longint'(a + c);
    e1 = 64 * longint'(a - c);
    o0 = 83 * longint'(b) + 36 * longint'(d);
    o1 = 36 * longint'(b) - 83 * longint'(d);
    s[0] = e0 + o0;
    s[1] = e1 + o1;
    s[2] = e1 - o1;
    s[3] = e0 - o0;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      v = (s[i] + 8192) >>> 14;
      if (v > 511) begin
        v = 511;
        r[40] = 1'b1;
      end else if (v < -512) begin
        v = -512;
        r[40] = 1'b1;
      end
      r[39-10*i -: 10] = v[9:0];
    end
    return r;
  endfunction

  function automatic logic signed [18:0] rnd19(input int k);
    logic signed [18:0] v;
    v = 19'($urandom);
    return (k % 2 == 1) ? v >>> 8 : v;
  endfunction

  // one clock: drive at negedge, record accept (pushing the model result) and observe the output side
  task automatic step(input logic iv, input logic signed [18:0] a, input logic signed [18:0] b,
                      input logic signed [18:0] c, input logic signed [18:0] d, input logic ordy,
                      output logic got, output logic acc, output logic [40:0] obs);
    @(negedge clk);
    in_valid = iv;
    y0 = a; y1 = b; y2 = c; y3 = d;
    out_ready = ordy;
    #1;
    got = out_valid && out_ready;
    acc = in_valid && in_ready;
    obs = {sat, x0, x1, x2, x3};
    if (acc) q.push_back(model(a, b, c, d));
  endtask

  task automatic test_reset;
    rst = 1;
    in_valid = 0;
    out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, in_ready, sat, x0, x1, x2, x3} !== {1'b0, 1'b1, 1'b0, 40'd0}) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: got v=%b r=%b s=%b x=%h want v=0 r=1 s=0 x=0",
                 k, out_valid, in_ready, sat, {x0, x1, x2, x3});
      end
    end
  endtask

  task automatic test_single(input string nm, input logic signed [18:0] a, input logic signed [18:0] b,
                             input logic signed [18:0] c, input logic signed [18:0] d, input logic [40:0] exp);
    logic got, acc;
    logic [40:0] obs;
    int first, cnt;
    first = -1;
    cnt = 0;
    q.delete();
    step(1, a, b, c, d, 1, got, acc, obs);
    for (int k = 1; k < 9; k++) begin
      step(0, 0, 0, 0, 0, 1, got, acc, obs);
      if (got) begin
        cnt++;
        if (first < 0) first = k;
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL %s value: got %h want %h", nm, obs, exp);
        end
      end
    end
    vectors++;
    if (first !== 3 || cnt !== 1) begin
      errors++;
      $display("FAIL %s timing: first=%0d count=%0d want first=3 count=1", nm, first, cnt);
    end
    q.delete();
  endtask

  task automatic test_back_to_back;
    logic got, acc, ordy;
    logic [40:0] obs, held, exp;
    logic signed [18:0] a, b, c, d;
    int sent, recv;
    sent = 0;
    recv = 0;
    held = '0;
    q.delete();
    a = rnd19(0); b = rnd19(1); c = rnd19(0); d = rnd19(1);
    for (int t = 0; t < 40 && recv < 8; t++) begin
      ordy = !(t >= 5 && t < 9);
      step(sent < 8, a, b, c, d, ordy, got, acc, obs);
      if (acc) begin
        sent++;
        a = rnd19(sent); b = rnd19(sent + 1); c = rnd19(sent); d = rnd19(sent + 1);
      end
      if (!ordy && out_valid) begin
        if (t == 5) held = obs;
        vectors++;
        if (in_ready !== 1'b0 || obs !== held) begin
          errors++;
          $display("FAIL stall t=%0d: in_ready=%b out=%h want in_ready=0 out=%h", t, in_ready, obs, held);
        end
      end
      if (got) begin
        recv++;
        exp = q.size() > 0 ? q.pop_front() : 'x;
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL b2b result %0d: got %h want %h", recv, obs, exp);
        end
      end
    end
    vectors++;
    if (recv !== 8 || q.size() !== 0) begin
      errors++;
      $display("FAIL b2b count: received %0d left %0d want 8 and 0", recv, q.size());
    end
  endtask

  task automatic test_reset_flush;
    logic got, acc;
    logic [40:0] obs, exp;
    int first;
    q.delete();
    step(1, 19'sd640, 19'sd830, 19'sd640, 19'sd360, 1, got, acc, obs);
    step(1, -19'sd5000, 19'sd1234, 19'sd77, -19'sd999, 1, got, acc, obs);
    @(negedge clk);
    rst = 1;
    in_valid = 1;
    y0 = 19'sd4000;
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    q.delete();
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 0, 0, 0, 1, got, acc, obs);
      vectors++;
      if (out_valid !== 1'b0 || obs !== 41'd0) begin
        errors++;
        $display("FAIL flush idle %0d: out_valid=%b out=%h want 0 and 0", k, out_valid, obs);
      end
    end
    first = -1;
    step(1, 19'sd100, -19'sd200, 19'sd300, -19'sd50, 1, got, acc, obs);
    for (int k = 1; k < 9; k++) begin
      step(0, 0, 0, 0, 0, 1, got, acc, obs);
      if (got) begin
        if (first < 0) first = k;
        exp = q.size() > 0 ? q.pop_front() : 'x;
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL flush next value: got %h want %h", obs, exp);
        end
      end
    end
    vectors++;
    if (first !== 3 || q.size() !== 0) begin
      errors++;
      $display("FAIL flush next timing: first=%0d left=%0d want 3 and 0", first, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single("pos", 19'sd640, 19'sd830, 19'sd640, 19'sd360, {1'b0, 10'd10, 10'd0, 10'd0, 10'd0});
    test_single("neg", -19'sd640, -19'sd830, -19'sd640, -19'sd360, {1'b0, 10'h3F6, 10'd0, 10'd0, 10'd0});
    test_single("sat_hi", 19'sd262143, 19'sd0, 19'sd0, 19'sd0, {1'b1, 10'h1FF, 10'h1FF, 10'h1FF, 10'h1FF});
    test_single("sat_lo", -19'sd262144, 19'sd0, 19'sd0, 19'sd0, {1'b1, 10'h200, 10'h200, 10'h200, 10'h200});
    test_back_to_back();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
